// File: rtl/vreg_report_pkg.sv
// rtl/vreg_report_pkg.sv - shared types, limits and group legality check for the vreg report scheduler
package vreg_report_pkg;

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_e;
    typedef enum logic {SRC_WB = 1'b0, SRC_ST = 1'b1} src_e;

    localparam int MAX_GROUP = 8;
    localparam int NUM_VREGS = 32;

    // Power-of-two size up to 8, naturally aligned base, and the group must fit in the register file.
    function automatic logic legal_group(input logic [7:0] addr, input logic [7:0] size);
        logic       pow2;
        logic [8:0] w_end;
        pow2  = (size == 8'd1) || (size == 8'd2) || (size == 8'd4) || (size == 8'd8);
        w_end = {1'b0, addr} + {1'b0, size};
        return pow2 && ((addr & (size - 8'd1)) == 8'd0) && (w_end <= 9'(NUM_VREGS));
    endfunction

endpackage

// File: rtl/vreg_report_rr_arb.sv
// rtl/vreg_report_rr_arb.sv - two-way round-robin arbiter that advances once per accepted group start
module vreg_report_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       start,
    input  logic       flush,
    output logic [1:0] grant
);

    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (!flush) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (start) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule

// File: rtl/vreg_report_sched.sv
// rtl/vreg_report_sched.sv - assembles vector-register groups from writeback and store requesters into single-cycle reports
import vreg_report_pkg::*;

module vreg_report_sched #(
    parameter int VLEN = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [7:0]      wb_rf_addr,
    input  logic [7:0]      wb_group_size,
    input  logic [VLEN-1:0] wb_data,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [7:0]      st_rf_addr,
    input  logic [7:0]      st_group_size,
    input  logic [VLEN-1:0] st_data,
    output logic            out_enable,
    output logic            out_is_store,
    output logic            out_wr_rf,
    output logic [7:0]      out_rf_addr,
    output logic [7:0]      out_rf_group_size,
    output logic [VLEN-1:0] out_data_0,
    output logic [VLEN-1:0] out_data_1,
    output logic [VLEN-1:0] out_data_2,
    output logic [VLEN-1:0] out_data_3,
    output logic [VLEN-1:0] out_data_4,
    output logic [VLEN-1:0] out_data_5,
    output logic [VLEN-1:0] out_data_6,
    output logic [VLEN-1:0] out_data_7,
    output logic            err_illegal,
    output logic            busy,
    output logic [31:0]     report_cnt
);

    state_e          r_state;
    src_e            r_src;
    logic [2:0]      r_cnt;
    logic [7:0]      r_addr;
    logic [7:0]      r_size;
    logic [VLEN-1:0] r_buf [MAX_GROUP];

    logic            r_out_en;
    logic            r_out_st;
    logic            r_out_wb;
    logic [7:0]      r_out_addr;
    logic [7:0]      r_out_size;
    logic [VLEN-1:0] r_out_data [MAX_GROUP];
    logic            r_err;
    logic [31:0]     r_rep_cnt;

    logic [1:0]      w_grant;
    logic            w_idle;
    logic            w_sel_st;
    logic            w_acc;
    logic            w_start;
    logic            w_legal;
    logic            w_last_cnt;
    logic            w_emit;
    logic [7:0]      w_in_addr;
    logic [7:0]      w_in_size;
    logic [VLEN-1:0] w_in_data;
    logic [7:0]      w_em_addr;
    logic [7:0]      w_em_size;
    logic [VLEN-1:0] w_merge [MAX_GROUP];

    assign w_idle    = (r_state == IDLE);
    assign wb_ready  = w_idle ? w_grant[0] : (~flush & (r_src == SRC_WB));
    assign st_ready  = w_idle ? w_grant[1] : (~flush & (r_src == SRC_ST));
    assign w_sel_st  = w_idle ? w_grant[1] : (r_src == SRC_ST);
    assign w_acc     = (wb_valid & wb_ready) | (st_valid & st_ready);
    assign w_start   = w_idle & w_acc;

    assign w_in_addr = w_sel_st ? st_rf_addr    : wb_rf_addr;
    assign w_in_size = w_sel_st ? st_group_size : wb_group_size;
    assign w_in_data = w_sel_st ? st_data       : wb_data;

    assign w_legal    = legal_group(w_in_addr, w_in_size);
    assign w_last_cnt = ({5'd0, r_cnt} == (r_size - 8'd1));
    assign w_emit     = w_acc & (w_idle ? (w_legal & (w_in_size == 8'd1)) : w_last_cnt);
    assign w_em_addr  = w_idle ? w_in_addr : r_addr;
    assign w_em_size  = w_idle ? w_in_size : r_size;

    // A size-1 group never touches the buffer, so only segment 0 carries data.
    always_comb begin
        for (int k = 0; k < MAX_GROUP; k++) begin
            w_merge[k] = '0;
            if (w_idle) begin
                if (k == 0) w_merge[k] = w_in_data;
            end else begin
                w_merge[k] = (r_cnt == 3'(k)) ? w_in_data : r_buf[k];
            end
        end
    end

    vreg_report_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid ({st_valid, wb_valid}),
        .start (w_start),
        .flush (flush),
        .grant (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_src   <= SRC_WB;
            r_cnt   <= 3'd0;
            r_addr  <= 8'd0;
            r_size  <= 8'd0;
            for (int k = 0; k < MAX_GROUP; k++) r_buf[k] <= '0;
        end else if (w_idle) begin
            if (w_start) begin
                r_addr   <= w_in_addr;
                r_size   <= w_in_size;
                r_src    <= w_sel_st ? SRC_ST : SRC_WB;
                r_buf[0] <= w_in_data;
                for (int k = 1; k < MAX_GROUP; k++) r_buf[k] <= '0;
                if (w_legal && (w_in_size != 8'd1)) begin
                    r_state <= COLLECT;
                    r_cnt   <= 3'd1;
                end
            end
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else if (w_acc) begin
            r_buf[r_cnt] <= w_in_data;
            if (w_last_cnt) begin
                r_state <= IDLE;
                r_cnt   <= 3'd0;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // Output register is independent of the assembly buffer so a new group may start while reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_en   <= 1'b0;
            r_out_st   <= 1'b0;
            r_out_wb   <= 1'b0;
            r_out_addr <= 8'd0;
            r_out_size <= 8'd0;
            r_err      <= 1'b0;
            r_rep_cnt  <= 32'd0;
            for (int k = 0; k < MAX_GROUP; k++) r_out_data[k] <= '0;
        end else begin
            r_out_en <= w_emit;
            r_err    <= w_start & ~w_legal;
            if (w_emit) begin
                r_out_st   <= w_sel_st;
                r_out_wb   <= ~w_sel_st;
                r_out_addr <= w_em_addr;
                r_out_size <= w_em_size;
                r_rep_cnt  <= r_rep_cnt + 32'd1;
                for (int k = 0; k < MAX_GROUP; k++) r_out_data[k] <= w_merge[k];
            end
        end
    end

    assign out_enable        = r_out_en;
    assign out_is_store      = r_out_st;
    assign out_wr_rf         = r_out_wb;
    assign out_rf_addr       = r_out_addr;
    assign out_rf_group_size = r_out_size;
    assign out_data_0        = r_out_data[0];
    assign out_data_1        = r_out_data[1];
    assign out_data_2        = r_out_data[2];
    assign out_data_3        = r_out_data[3];
    assign out_data_4        = r_out_data[4];
    assign out_data_5        = r_out_data[5];
    assign out_data_6        = r_out_data[6];
    assign out_data_7        = r_out_data[7];
    assign err_illegal       = r_err;
    assign busy              = (r_state == COLLECT);
    assign report_cnt        = r_rep_cnt;

endmodule

// File: tb/tb_vreg_report_sched.sv
// tb/tb_vreg_report_sched.sv - scoreboard bench for vreg_report_sched
module tb_vreg_report_sched;

    localparam int VLEN = 1024;

    typedef struct packed {
        logic                 st;
        logic [7:0]           addr;
        logic [7:0]           size;
        logic [31:0]          cnt;
        logic [7:0][VLEN-1:0] d;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            wb_valid, wb_ready, st_valid, st_ready;
    logic [7:0]      wb_rf_addr, wb_group_size, st_rf_addr, st_group_size;
    logic [VLEN-1:0] wb_data, st_data;
    logic            out_enable, out_is_store, out_wr_rf, err_illegal, busy;
    logic [7:0]      out_rf_addr, out_rf_group_size;
    logic [VLEN-1:0] out_data_0, out_data_1, out_data_2, out_data_3;
    logic [VLEN-1:0] out_data_4, out_data_5, out_data_6, out_data_7;
    logic [31:0]     report_cnt;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_cnt = 0;
    int   err_seen = 0;
    int   run = 0;
    int   max_run = 0;

    vreg_report_sched #(.VLEN(VLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rf_addr(wb_rf_addr),
        .wb_group_size(wb_group_size), .wb_data(wb_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_rf_addr(st_rf_addr),
        .st_group_size(st_group_size), .st_data(st_data),
        .out_enable(out_enable), .out_is_store(out_is_store), .out_wr_rf(out_wr_rf),
        .out_rf_addr(out_rf_addr), .out_rf_group_size(out_rf_group_size),
        .out_data_0(out_data_0), .out_data_1(out_data_1), .out_data_2(out_data_2),
        .out_data_3(out_data_3), .out_data_4(out_data_4), .out_data_5(out_data_5),
        .out_data_6(out_data_6), .out_data_7(out_data_7),
        .err_illegal(err_illegal), .busy(busy), .report_cnt(report_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [VLEN-1:0] mk(input logic [31:0] x);
        return {(VLEN/32){x}};
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chkd(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s actual(low64)=%h required(low64)=%h", nm, act[63:0], req[63:0]);
        end
    endtask

    task automatic push(input logic st, input logic [7:0] a, input logic [7:0] s,
                        input logic [7:0][VLEN-1:0] d);
        exp_t e;
        exp_cnt++;
        e.st = st; e.addr = a; e.size = s; e.cnt = 32'(exp_cnt); e.d = d;
        sb.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the beat was accepted.
    task automatic beat(input bit src, input logic [7:0] a, input logic [7:0] s, input logic [VLEN-1:0] d);
        int n;
        if (src) begin
            st_valid = 1'b1; st_rf_addr = a; st_group_size = s; st_data = d;
        end else begin
            wb_valid = 1'b1; wb_rf_addr = a; wb_group_size = s; wb_data = d;
        end
        n = 0;
        #1;
        while (!(src ? st_ready : wb_ready) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) begin
            n_cmp++; n_mis++;
            $display("FAIL beat_timeout src=%0d actual_ready=0 required_ready=1", src);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_enable) begin
                exp_t e;
                logic [7:0][VLEN-1:0] a;
                run++;
                if (run > max_run) max_run = run;
                a = {out_data_7, out_data_6, out_data_5, out_data_4,
                     out_data_3, out_data_2, out_data_1, out_data_0};
                if (sb.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL unexpected_report actual_addr=%0d required=none", out_rf_addr);
                end else begin
                    e = sb.pop_front();
                    chk32("is_store", 32'(out_is_store), 32'(e.st));
                    chk32("wr_rf", 32'(out_wr_rf), 32'(!e.st));
                    chk32("rf_addr", 32'(out_rf_addr), 32'(e.addr));
                    chk32("group_size", 32'(out_rf_group_size), 32'(e.size));
                    chk32("report_cnt", report_cnt, e.cnt);
                    for (int k = 0; k < 8; k++) chkd($sformatf("data_%0d", k), a[k], e.d[k]);
                end
            end else begin
                run = 0;
            end
            if (err_illegal) err_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0][VLEN-1:0] d, d2;
        logic [7:0] ill_a [4];
        logic [7:0] ill_s [4];
        ill_s[0] = 8'd3; ill_a[0] = 8'd0;
        ill_s[1] = 8'd4; ill_a[1] = 8'd6;
        ill_s[2] = 8'd8; ill_a[2] = 8'd28;
        ill_s[3] = 8'd1; ill_a[3] = 8'd32;

        rst_n = 1'b0; flush = 1'b0;
        wb_valid = 1'b0; wb_rf_addr = '0; wb_group_size = '0; wb_data = '0;
        st_valid = 1'b0; st_rf_addr = '0; st_group_size = '0; st_data = '0;
        repeat (2) @(negedge clk);
        chk32("rst_out_enable", 32'(out_enable), 32'd0);
        chk32("rst_report_cnt", report_cnt, 32'd0);
        chk32("rst_busy", 32'(busy), 32'd0);
        chk32("rst_err", 32'(err_illegal), 32'd0);
        chk32("rst_rf_addr", 32'(out_rf_addr), 32'd0);
        chkd("rst_data_0", out_data_0, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single size-1 writeback group
        d = '0; d[0] = mk(32'hA0A0_0005);
        push(1'b0, 8'd5, 8'd1, d);
        beat(1'b0, 8'd5, 8'd1, mk(32'hA0A0_0005));
        chk32("t1_out_enable", 32'(out_enable), 32'd1);
        chk32("t1_report_cnt", report_cnt, 32'd1);
        wb_valid = 1'b0;
        @(negedge clk);
        chk32("t1_enable_drop", 32'(out_enable), 32'd0);

        // Store size 8 with a gap after beat 3
        for (int k = 0; k < 8; k++) d[k] = mk(32'hD000_0000 + 32'(k));
        push(1'b1, 8'd8, 8'd8, d);
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, 8'd8, 8'd8, mk(32'hD000_0000 + 32'(k)));
            if (k == 3) begin
                st_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            chk32($sformatf("t3_busy_%0d", k), 32'(busy), (k < 7) ? 32'd1 : 32'd0);
        end
        st_valid = 1'b0;
        @(negedge clk);

        // Both requesters with size-2 groups: writeback first, then store
        d = '0; d[0] = mk(32'hB000_0020); d[1] = mk(32'hB000_0021);
        push(1'b0, 8'd2, 8'd2, d);
        d2 = '0; d2[0] = mk(32'hC000_0040); d2[1] = mk(32'hC000_0041);
        push(1'b1, 8'd4, 8'd2, d2);
        fork
            begin
                beat(1'b0, 8'd2, 8'd2, mk(32'hB000_0020));
                beat(1'b0, 8'd2, 8'd2, mk(32'hB000_0021));
                wb_valid = 1'b0;
            end
            begin
                beat(1'b1, 8'd4, 8'd2, mk(32'hC000_0040));
                beat(1'b1, 8'd4, 8'd2, mk(32'hC000_0041));
                st_valid = 1'b0;
            end
        join
        // Pointer is back on writeback: a simultaneous pair goes wb then st
        d = '0; d[0] = mk(32'hE000_000A);
        push(1'b0, 8'd10, 8'd1, d);
        d2 = '0; d2[0] = mk(32'hE000_000B);
        push(1'b1, 8'd11, 8'd1, d2);
        fork
            begin beat(1'b0, 8'd10, 8'd1, mk(32'hE000_000A)); wb_valid = 1'b0; end
            begin beat(1'b1, 8'd11, 8'd1, mk(32'hE000_000B)); st_valid = 1'b0; end
        join
        @(negedge clk);

        // Illegal groups
        for (int i = 0; i < 4; i++) begin
            beat(1'b0, ill_a[i], ill_s[i], mk(32'hBAD0_0000 + 32'(i)));
            chk32($sformatf("ill_err_%0d", i), 32'(err_illegal), 32'd1);
            chk32($sformatf("ill_noreport_%0d", i), 32'(out_enable), 32'd0);
            chk32($sformatf("ill_busy_%0d", i), 32'(busy), 32'd0);
            wb_valid = 1'b0;
            @(negedge clk);
        end

        // Flush a partial group, then a normal size-1 group
        beat(1'b0, 8'd0, 8'd4, mk(32'hF000_0000));
        beat(1'b0, 8'd0, 8'd4, mk(32'hF000_0001));
        chk32("fl_busy_before", 32'(busy), 32'd1);
        wb_data = mk(32'hF000_0002);
        flush = 1'b1;
        #1;
        chk32("fl_ready_gated", 32'(wb_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        wb_valid = 1'b0;
        chk32("fl_busy_after", 32'(busy), 32'd0);
        d = '0; d[0] = mk(32'h6000_0001);
        push(1'b0, 8'd1, 8'd1, d);
        beat(1'b0, 8'd1, 8'd1, mk(32'h6000_0001));
        wb_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a group
        beat(1'b0, 8'd4, 8'd4, mk(32'h7000_0000));
        beat(1'b0, 8'd4, 8'd4, mk(32'h7000_0001));
        wb_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk32("ar_out_enable", 32'(out_enable), 32'd0);
        chk32("ar_rf_addr", 32'(out_rf_addr), 32'd0);
        chk32("ar_report_cnt", report_cnt, 32'd0);
        chk32("ar_busy", 32'(busy), 32'd0);
        chkd("ar_data_0", out_data_0, '0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ten back-to-back size-1 groups
        max_run = 0;
        for (int k = 0; k < 10; k++) begin
            d = '0; d[0] = mk(32'h9000_0000 + 32'(k));
            push(1'b0, 8'(k), 8'd1, d);
        end
        for (int k = 0; k < 10; k++) beat(1'b0, 8'(k), 8'd1, mk(32'h9000_0000 + 32'(k)));
        wb_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk32("b2b_run", 32'(max_run), 32'd10);
        chk32("b2b_report_cnt", report_cnt, 32'd10);

        repeat (4) @(negedge clk);
        chk32("sb_drained", 32'(sb.size()), 32'd0);
        chk32("err_pulses", 32'(err_seen), 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/vreg_report_sched.md
Name: vreg_report_sched

Overview:
- Collects per-register vector-register beats from two requesters and assembles each register group (1/2/4/8 registers).
- Requester 0 is writeback (register-file write); requester 1 is store-source read.
- Arbitrates between them round-robin at group granularity.
- Emits one single-cycle report carrying the whole group to the vreg DPI reporting block. That block has no backpressure, so this scheduler owns all sequencing.

Parameters:
- VLEN, 1024: bits per vector register; width of every data port.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any partial group
- wb_valid  in  1  writeback beat valid
- wb_ready  out  1  writeback beat accepted this cycle (when wb_valid)
- wb_rf_addr  in  8  group base register; sampled on the first beat only
- wb_group_size  in  8  registers in the group; sampled on the first beat only
- wb_data  in  VLEN  one register per beat, in ascending register order
- st_valid, st_ready, st_rf_addr, st_group_size, st_data  same as the wb_* ports, for the store requester
- out_enable  out  1  report strobe, one cycle per group
- out_is_store  out  1  1 = group came from the store requester
- out_wr_rf  out  1  1 = group came from the writeback requester
- out_rf_addr  out  8  group base register
- out_rf_group_size  out  8  group size
- out_data_0 .. out_data_7  out  VLEN each  registers base+0 .. base+7; unused segments are 0
- err_illegal  out  1  one-cycle pulse on a rejected group
- busy  out  1  high while in COLLECT
- report_cnt  out  32  number of reports emitted; wraps modulo 2^32

Behaviour:
- Reset (rst_n low, asynchronous): every output 0; state IDLE; beat counter 0; round-robin pointer = wb; assembly buffer 0.
- Reset mid-group discards the partial group; no report is emitted.
- States: IDLE, COLLECT.
- Readies are combinational, always gated by ~flush, and are the only accept condition (accept = valid & ready).
- Arbitration (IDLE only):
  - If only one requester is valid, it wins.
  - If both are valid, the pointer's requester wins.
  - The loser's ready is 0.
  - The pointer flips to the other requester after any group start (accepted first beat), including rejected groups.
- First-beat acceptance:
  - Latch rf_addr, group_size and source.
  - Store data in buffer segment 0 and zero segments 1..7.
- Legality check on the first beat:
  - group_size must be in {1,2,4,8}.
  - rf_addr must be a multiple of group_size (low bits zero).
  - rf_addr + group_size must be <= 32.
  - If illegal: the beat is consumed, err_illegal pulses the next cycle, no report is emitted, state stays IDLE.
- A legal group of size 1 emits directly and stays IDLE.
- A legal group of size > 1 moves to COLLECT with cnt = 1.
- COLLECT:
  - Only the owning requester's ready = ~flush; the other's ready = 0.
  - Each accepted beat writes segment cnt, then cnt increments.
  - The beat with cnt == group_size-1 is final: emit, then return to IDLE.
  - Idle cycles (no valid) are allowed indefinitely; no timeout.
- Emit timing:
  - The out_* fields are registered from the buffer merged with the final beat.
  - out_enable is high for exactly the cycle after the final beat is accepted.
  - Fields hold their last values after out_enable drops.
  - report_cnt increments in the same cycle out_enable is high.
- Throughput: a new first beat may be accepted in the same cycle out_enable is high, because the output register is separate from the assembly buffer. Back-to-back size-1 groups therefore give one report per cycle.
- flush:
  - In COLLECT: discard the partial group, go to IDLE next cycle, no report, no error; the pointer is unchanged.
  - In IDLE: no effect other than holding readies at 0.
  - Flush does not cancel an out_enable already registered.
- Data width: no arithmetic beyond the 3-bit cnt and the 9-bit addr+size check; out_rf_group_size passes through unmodified.

Decomposition:
- Shared package vreg_report_pkg holds:
  - enum state_e {IDLE, COLLECT}
  - enum src_e {SRC_WB, SRC_ST}
  - constants MAX_GROUP = 8, NUM_VREGS = 32
  - function legal_group(addr, size)
- One natural sub-module: vreg_report_rr_arb. It is the 2-way group-granular round-robin arbiter, with inputs valid[1:0], start and flush, and output grant[1:0].

Test Plan:
- wb sends size 1, addr 5, data A -> out_enable exactly 1 cycle later; out_wr_rf = 1, out_is_store = 0, out_rf_addr = 5, out_data_0 = A, others 0; report_cnt = 1.
- wb and st both valid with size-2 groups (wb addr 2, st addr 4) -> wb fully served first (st_ready stays 0 meanwhile), then st; two reports with the correct source flags; the pointer returns to wb.
- st size 8, addr 8, beats D0..D7 with a 3-cycle valid gap after beat 3 -> one report with out_data_k = Dk, out_is_store = 1, busy high throughout the collection.
- Illegal requests: size 3 -> beat consumed, err_illegal pulse, no out_enable. Separately, size 4 at addr 6 and size 8 at addr 28 -> the same rejection.
- wb size 4 addr 0, flush after 2 beats -> no report; next wb size 1 addr 1 reports normally with segments 1..7 = 0; async reset asserted mid-group -> all outputs 0 immediately.
- 10 back-to-back size-1 wb beats -> 10 consecutive out_enable cycles, no bubbles; report_cnt = 10.
